i2s_byte_packer: RTL

- Converts multichannel PCM samples from the slow I2S/decimator clock domain into a byte stream on the system clock, ready to feed the byte-wide TX FIFO that the SPI slave drains.
- Generalises the fixed 24-bit, 3-byte write sequencer with:
  - parametrised sample width, output byte count and channel count;
  - optional per-sample channel header byte and selectable byte order;
  - a channel mask;
  - a counter of samples dropped on overrun.
- Sits between the sample_reduce/receiver outputs and the FIFO write port.

---
 rtl/i2s_byte_packer.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_byte_packer.sv
// ---------------------------------------------------------------------------
// i2s_byte_packer
//
// Turns PCM samples arriving from the slow I2S / decimator clock domain into
// a byte stream on the system clock. The stream feeds the byte-wide TX FIFO
// that the SPI slave drains.
//
// A sample is captured on the rising edge of the slow sample_done_i strobe.
// That strobe is synchronised by two flops, and a third flop remembers the
// previous level. Each sample is formatted as follows:
//   - optionally, one header byte {4'hA, channel} goes first;
//   - then OUT_BYTES data bytes follow, LSB-first or MSB-first.
// A qualifying edge that arrives while a stream is still in progress is
// discarded and counted in drop_count_o. That counter saturates.
//
// Ports
//   clk            system clock
//   rst_n          synchronous, active-low reset
//   enable_i       1 = accept samples, 0 = ignore sample edges (not counted)
//   ch_mask_i      bit n = 1 enables channel n
//   sample_done_i  level strobe from the slow domain (>=2 clk high / low)
//   sample_i       sample data, signed, stable while sample_done_i is high
//   ch_i           channel ID of sample_i, stable while sample_done_i is high
//   out_data_o     byte to write
//   out_valid_o    out_data_o is valid
//   out_ready_i    sink can accept a byte
//   busy_o         high while a sample is being emitted
//   drop_count_o   samples lost to overrun, saturating at 16'hFFFF
//
// Handshake: a byte moves on the rising clk edge where out_valid_o and
// out_ready_i are both high. out_valid_o/out_data_o are registered and held
// until that transfer. out_valid_o never depends combinationally on
// out_ready_i.
// ---------------------------------------------------------------------------
module i2s_byte_packer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int OUT_BYTES    = 3,
    parameter int NUM_CHANNELS = 2,
    parameter int HEADER_EN    = 1,
    parameter int MSB_FIRST    = 0,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [NUM_CHANNELS-1:0] ch_mask_i,
    input  logic                    sample_done_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    input  logic [CH_W-1:0]         ch_i,
    output logic [7:0]              out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    busy_o,
    output logic [15:0]             drop_count_o
);

    localparam int         OW       = OUT_BYTES * 8;
    localparam int         MASK_W   = 1 << CH_W;
    localparam logic [1:0] LAST_IDX = 2'(OUT_BYTES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]    sync_q,  sync_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    idx_q,   idx_d;
    logic [OW-1:0] word_q,  word_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q,  data_d;
    logic [15:0]   drop_q,  drop_d;

    // -----------------------------------------------------------------------
    // Strobe synchroniser and edge detection.
    // sync_q[0] and sync_q[1] form the two-flop synchroniser. sync_q[2]
    // holds the previous synchronised level. All three flops reset to 1.
    // Because of that, a strobe that is already high when reset is
    // released looks like a steady level and not a new edge.
    // -----------------------------------------------------------------------
    logic edge_pulse;

    assign edge_pulse = sync_q[1] & ~sync_q[2];

    // -----------------------------------------------------------------------
    // Channel qualification.
    // The mask is widened to cover every value ch_i can encode. IDs at or
    // above NUM_CHANNELS therefore look up a zero bit and are treated as
    // masked.
    // -----------------------------------------------------------------------
    logic [MASK_W-1:0] mask_ext;

    always_comb begin
        mask_ext = '0;
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            mask_ext[n] = ch_mask_i[n];
        end
    end

    logic qualify;

    assign qualify = edge_pulse & enable_i & mask_ext[ch_i];

    // -----------------------------------------------------------------------
    // Word formation.
    // Narrow outputs keep the MSBs of the sample. Wide outputs sign-extend
    // the sample.
    // -----------------------------------------------------------------------
    logic [OW-1:0] word_new;

    generate
        if (OW < SAMPLE_WIDTH) begin : g_trunc
            logic unused_lsbs;
            assign word_new    = sample_i[SAMPLE_WIDTH-1 -: OW];
            assign unused_lsbs = ^sample_i[SAMPLE_WIDTH-OW-1:0];
        end else if (OW > SAMPLE_WIDTH) begin : g_sext
            assign word_new = {{(OW - SAMPLE_WIDTH){sample_i[SAMPLE_WIDTH-1]}}, sample_i};
        end else begin : g_pass
            assign word_new = sample_i;
        end
    endgenerate

    logic [7:0] header_new;

    assign header_new = {4'hA, 4'(ch_i)};

    // Returns byte number k of the stream. Byte 0 is the word's LSB when
    // the order is LSB-first, and its MSB when the order is MSB-first.
    function automatic logic [7:0] pick_byte(input logic [OW-1:0] w,
                                             input logic [1:0]    k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (k == 2'(i)) begin
                if (MSB_FIRST != 0) begin
                    b = w[8*(OUT_BYTES-1-i) +: 8];
                end else begin
                    b = w[8*i +: 8];
                end
            end
        end
        return b;
    endfunction

    // -----------------------------------------------------------------------
    // Capture / overrun decision.
    // A new sample may load while the FSM is idle. It may also load in the
    // same cycle that the final data byte leaves, so back-to-back samples
    // lose no cycle. A qualifying edge at any other busy time is an overrun.
    // -----------------------------------------------------------------------
    logic xfer;
    logic last_xfer;
    logic can_capture;
    logic capture;
    logic drop_evt;

    assign xfer        = valid_q & out_ready_i;
    assign last_xfer   = (state_q == ST_DATA) & xfer & (idx_q == LAST_IDX);
    assign can_capture = (state_q == ST_IDLE) | last_xfer;
    assign capture     = qualify & can_capture;
    assign drop_evt    = qualify & ~can_capture;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic load_new;

    always_comb begin
        sync_d   = {sync_q[1:0], sample_done_i};
        state_d  = state_q;
        idx_d    = idx_q;
        word_d   = word_q;
        valid_d  = valid_q;
        data_d   = data_q;
        drop_d   = drop_q;
        load_new = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    load_new = 1'b1;
                end
            end

            ST_HDR: begin
                if (xfer) begin
                    state_d = ST_DATA;
                    idx_d   = 2'd0;
                    data_d  = pick_byte(word_q, 2'd0);
                end
            end

            ST_DATA: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        if (capture) begin
                            load_new = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            idx_d   = 2'd0;
                            valid_d = 1'b0;
                            data_d  = 8'h00;
                        end
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        data_d = pick_byte(word_q, idx_q + 2'd1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                valid_d = 1'b0;
                data_d  = 8'h00;
            end
        endcase

        // Load a freshly captured sample. Its first byte is presented
        // immediately, so it appears one cycle after the capture edge.
        if (load_new) begin
            word_d  = word_new;
            valid_d = 1'b1;
            idx_d   = 2'd0;
            if (HEADER_EN != 0) begin
                state_d = ST_HDR;
                data_d  = header_new;
            end else begin
                state_d = ST_DATA;
                data_d  = pick_byte(word_new, 2'd0);
            end
        end

        if (drop_evt && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 3'b111;
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            word_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            drop_q  <= 16'h0000;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign out_data_o   = data_q;
    assign out_valid_o  = valid_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign drop_count_o = drop_q;

endmodule
